// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// port index constants and the legal memory-latency range.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin chooser; the pointer names the preferred port
// and moves to the port that was not served once an access finishes.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= P0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_valid = |req;
    grant_idx   = P0;
    if (req[0] && req[1]) begin
      grant_idx = ptr;
    end else if (req[1]) begin
      grant_idx = P1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the MEM-stage port and the loader/debug port onto a single
// fixed-latency data memory, one access at a time.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Out-of-range latencies are pulled back into what the 3-bit counter supports.
  localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       sel_idx;
  logic       lat_we;
  logic       grant_valid;
  logic       grant_idx;
  logic       grant_take;
  logic       capture;

  rr_arb2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         ({p1_req, p0_req}),
    .advance     (state == ST_DONE),
    .served      (sel_idx),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    grant_take = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = CNT_INIT;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The operand registers double as the memory-side address/data outputs,
  // so they naturally hold their values outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      sel_idx   <= P0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant_take) begin
        sel_idx   <= grant_idx;
        lat_we    <= (grant_idx == P1) ? p1_we    : p0_we;
        mem_addr  <= (grant_idx == P1) ? p1_addr  : p0_addr;
        mem_wdata <= (grant_idx == P1) ? p1_wdata : p0_wdata;
      end
      if (capture && !lat_we) begin
        if (sel_idx == P1) begin
          p1_rdata <= mem_rdata;
        end else begin
          p0_rdata <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_en   = (state == ST_ISSUE);
    mem_we   = (state == ST_ISSUE) && lat_we;
    busy     = (state != ST_IDLE);
    p0_done  = (state == ST_DONE) && (sel_idx == P0);
    p1_done  = (state == ST_DONE) && (sel_idx == P1);
    p0_stall = p0_req && !p0_done;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_dmem_arbiter;

  localparam int L = 2;

  logic        clk;
  logic        rst;
  logic        req_a   [2];
  logic        we_a    [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic        p0_done, p1_done, p0_stall;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (req_a[0]),
    .p0_we     (we_a[0]),
    .p0_addr   (addr_a[0]),
    .p0_wdata  (wdata_a[0]),
    .p0_done   (p0_done),
    .p0_rdata  (p0_rdata),
    .p0_stall  (p0_stall),
    .p1_req    (req_a[1]),
    .p1_we     (we_a[1]),
    .p1_addr   (addr_a[1]),
    .p1_wdata  (wdata_a[1]),
    .p1_done   (p1_done),
    .p1_rdata  (p1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'h5A5A0000 | 32'(i * 259));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory with a two-cycle read pipe; idle slots carry junk so that a
  // mistimed capture is visible.
  logic [31:0] mem_r     [64];
  bit          written_r [64];
  logic [31:0] pipe0, pipe1;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_r[mem_addr[7:2]]     <= mem_wdata;
      written_r[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      pipe0 <= written_r[mem_addr[7:2]] ? mem_r[mem_addr[7:2]] : init_word(int'(mem_addr[7:2]));
    end else begin
      pipe0 <= $urandom;
    end
    pipe1 <= pipe0;
  end
  assign mem_rdata = pipe1;

  // Transaction model: m_age counts cycles since the request was sampled
  // (0 = no access), so ISSUE is age 1 and done is age L+2.
  bit          model_valid = 1'b0;
  int          m_age = 0;
  bit          m_port, m_we, m_pref;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] exp_rdata   [2];
  logic [31:0] exp_mem     [64];
  bit          exp_written [64];

  always @(negedge clk) begin
    bit d0, d1, g;
    int idx;
    if (model_valid) begin
      d0 = (m_age == L + 2) && !m_port;
      d1 = (m_age == L + 2) && m_port;
      checkOutput("busy",      32'(busy),     32'(m_age != 0));
      checkOutput("mem_en",    32'(mem_en),   32'(m_age == 1));
      checkOutput("mem_we",    32'(mem_we),   32'((m_age == 1) && m_we));
      checkOutput("mem_addr",  mem_addr,      m_addr);
      checkOutput("mem_wdata", mem_wdata,     m_wdata);
      checkOutput("p0_done",   32'(p0_done),  32'(d0));
      checkOutput("p1_done",   32'(p1_done),  32'(d1));
      checkOutput("p0_stall",  32'(p0_stall), 32'(req_a[0] && !d0));
      checkOutput("p0_rdata",  p0_rdata,      exp_rdata[0]);
      checkOutput("p1_rdata",  p1_rdata,      exp_rdata[1]);
    end
    if (rst) begin
      model_valid  = 1'b1;
      m_age        = 0;
      m_pref       = 1'b0;
      m_port       = 1'b0;
      m_we         = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
    end else if (model_valid) begin
      if (m_age == 0) begin
        if (req_a[0] || req_a[1]) begin
          g       = (req_a[0] && req_a[1]) ? m_pref : req_a[1];
          m_port  = g;
          m_we    = we_a[g];
          m_addr  = addr_a[g];
          m_wdata = wdata_a[g];
          m_age   = 1;
        end
      end else if (m_age == L + 2) begin
        m_age  = 0;
        m_pref = !m_port;
      end else begin
        idx = int'(m_addr[7:2]);
        if (m_age == 1 && m_we) begin
          exp_mem[idx]     = m_wdata;
          exp_written[idx] = 1'b1;
        end
        if (m_age == L + 1 && !m_we) begin
          exp_rdata[m_port] = exp_written[idx] ? exp_mem[idx] : init_word(idx);
        end
        m_age++;
      end
    end
  end

  bit pending [2];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs;
    for (int p = 0; p < 2; p++) begin
      req_a[p]   = 1'b0;
      we_a[p]    = 1'b0;
      addr_a[p]  = '0;
      wdata_a[p] = '0;
      pending[p] = 1'b0;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_reqs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Requesters keep req/operands until their done cycle, may drop req once
  // granted, and may raise a fresh request in their own done cycle.
  task automatic applyStimulus(input bit allow_new);
    if (rst) begin
      for (int p = 0; p < 2; p++) if (!req_a[p]) pending[p] = 1'b0;
    end
    rst = allow_new && ($urandom_range(0, 149) == 0);
    for (int p = 0; p < 2; p++) begin
      bit done_now, in_flight;
      done_now  = (m_age == L + 2) && (m_port == p[0]);
      in_flight = (m_age != 0) && (m_port == p[0]);
      if (pending[p] && !done_now) begin
        if (req_a[p] && in_flight && $urandom_range(0, 7) == 0) req_a[p] = 1'b0;
      end else begin
        pending[p] = 1'b0;
        if (allow_new && $urandom_range(0, 2) == 0) begin
          req_a[p]   = 1'b1;
          we_a[p]    = 1'($urandom_range(0, 1));
          addr_a[p]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          wdata_a[p] = $urandom;
          pending[p] = 1'b1;
        end else begin
          req_a[p] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    do_reset();
    #2;
    $display("[TB] reset state");
    checkOutput("rst_busy",   32'(busy),   32'h0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
    checkOutput("rst_addr",   mem_addr,    32'h0);
    checkOutput("rst_rdata0", p0_rdata,    32'h0);
    checkOutput("rst_rdata1", p1_rdata,    32'h0);

    $display("[TB] single read");
    next_cycle();
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) next_cycle();
      #2;
      checkOutput("a_stall",  32'(p0_stall), 32'(c < 4));
      checkOutput("a_mem_en", 32'(mem_en),   32'(c == 1));
      checkOutput("a_done",   32'(p0_done),  32'(c == 4));
    end
    checkOutput("a_rdata", p0_rdata, 32'hDEADBEEF);
    next_cycle();
    req_a[0] = 1'b0;

    $display("[TB] contention");
    do_reset();
    req_a[0] = 1'b1; addr_a[0] = 32'h40;
    req_a[1] = 1'b1; addr_a[1] = 32'h44;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) next_cycle();
      if (c == 5) req_a[0] = 1'b0;
      #2;
      checkOutput("b_done0",  32'(p0_done), 32'(c == 4));
      checkOutput("b_done1",  32'(p1_done), 32'(c == 9));
      checkOutput("b_mem_en", 32'(mem_en),  32'(c == 1 || c == 6));
    end
    checkOutput("b_rdata1", p1_rdata, init_word(17));
    next_cycle();
    req_a[1] = 1'b0;

    $display("[TB] write then read");
    next_cycle();
    req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 32'h80; wdata_a[1] = 32'h1234;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) next_cycle();
      if (c == 5) begin
        req_a[1] = 1'b0; we_a[1] = 1'b0;
        req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 32'h80;
      end
      #2;
      checkOutput("c_mem_we", 32'(mem_we),  32'(c == 1));
      checkOutput("c_done1",  32'(p1_done), 32'(c == 4));
      checkOutput("c_done0",  32'(p0_done), 32'(c == 9));
      if (c == 1) checkOutput("c_wdata", mem_wdata, 32'h1234);
    end
    checkOutput("c_rdata0", p0_rdata, 32'h00001234);
    checkOutput("c_rdata1", p1_rdata, init_word(17));
    next_cycle();
    req_a[0] = 1'b0;

    $display("[TB] reset abort");
    do_reset();
    req_a[0] = 1'b1; addr_a[0] = 32'h40;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) next_cycle();
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0; req_a[0] = 1'b0;
        req_a[1] = 1'b1; addr_a[1] = 32'h48;
      end
      #2;
      checkOutput("d_done0", 32'(p0_done), 32'h0);
      checkOutput("d_done1", 32'(p1_done), 32'(c == 7));
      if (c == 3) begin
        checkOutput("d_busy",   32'(busy),   32'h0);
        checkOutput("d_mem_en", 32'(mem_en), 32'h0);
      end
    end
    next_cycle();
    req_a[1] = 1'b0;

    $display("[TB] fairness");
    do_reset();
    req_a[0] = 1'b1; addr_a[0] = 32'h10;
    req_a[1] = 1'b1; addr_a[1] = 32'h14;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) next_cycle();
      #2;
      checkOutput("e_done0", 32'(p0_done), 32'(c == 4 || c == 14));
      checkOutput("e_done1", 32'(p1_done), 32'(c == 9));
    end
    next_cycle();
    clear_reqs();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      applyStimulus(1'b1);
    end
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      applyStimulus(1'b0);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
